// File: rtl/alu_datapath_system.sv
// 8-bit teaching-CPU datapath: RF, ARF, IR, 256x8 RAM, ALU with flags, muxes.
// The RAM starts zeroed and is never altered by reset.
module alu_datapath_system (
  input  logic        Clock,
  input  logic        RESET,
  input  logic [1:0]  RF_OutASel,
  input  logic [1:0]  RF_OutBSel,
  input  logic [1:0]  RF_FunSel,
  input  logic [3:0]  RF_RegSel,
  input  logic [3:0]  ALU_FunSel,
  input  logic [1:0]  ARF_OutCSel,
  input  logic [1:0]  ARF_OutDSel,
  input  logic [1:0]  ARF_FunSel,
  input  logic [2:0]  ARF_RegSel,
  input  logic        IR_LH,
  input  logic        IR_Enable,
  input  logic [1:0]  IR_Funsel,
  input  logic        Mem_WR,
  input  logic        Mem_CS,
  input  logic [1:0]  MuxASel,
  input  logic [1:0]  MuxBSel,
  input  logic        MuxCSel,
  output logic [7:0]  AOut,
  output logic [7:0]  BOut,
  output logic [7:0]  ALUOut,
  output logic [3:0]  ALUOutFlag,
  output logic [7:0]  ARF_COut,
  output logic [7:0]  Address,
  output logic [7:0]  MemoryOut,
  output logic [15:0] IROut,
  output logic [7:0]  MuxAOut,
  output logic [7:0]  MuxBOut,
  output logic [7:0]  MuxCOut
);

  logic [7:0]  r [4];
  logic [7:0]  pc, ar, sp;
  logic [15:0] ir;
  logic        cstored;
  logic [3:0]  rf_we;
  logic [8:0]  sum;
  logic [7:0]  res;
  logic        c, o;

  logic [7:0] mem [256] = '{default: 8'h00};

  function automatic logic [7:0] reg_fun(
    input logic [7:0] q,
    input logic [1:0] f,
    input logic [7:0] d
  );
    unique case (f)
      2'b00:   return q - 8'd1;
      2'b01:   return q + 8'd1;
      2'b10:   return d;
      default: return 8'h00;
    endcase
  endfunction

  assign rf_we = ~{RF_RegSel[0], RF_RegSel[1], RF_RegSel[2], RF_RegSel[3]};

  always_ff @(posedge Clock or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 4; i++) r[i] <= 8'h00;
    end else begin
      for (int i = 0; i < 4; i++)
        if (rf_we[i]) r[i] <= reg_fun(r[i], RF_FunSel, MuxAOut);
    end
  end

  always_ff @(posedge Clock or posedge RESET) begin
    if (RESET) begin
      pc <= 8'h00;
      ar <= 8'h00;
      sp <= 8'h00;
    end else begin
      if (!ARF_RegSel[2]) pc <= reg_fun(pc, ARF_FunSel, MuxBOut);
      if (!ARF_RegSel[1]) ar <= reg_fun(ar, ARF_FunSel, MuxBOut);
      if (!ARF_RegSel[0]) sp <= reg_fun(sp, ARF_FunSel, MuxBOut);
    end
  end

  always_ff @(posedge Clock or posedge RESET) begin
    if (RESET) begin
      ir <= 16'h0000;
    end else if (IR_Enable) begin
      unique case (IR_Funsel)
        2'b00: ir <= ir - 16'd1;
        2'b01: ir <= ir + 16'd1;
        2'b10: begin
          if (IR_LH) ir[15:8] <= MemoryOut;
          else       ir[7:0]  <= MemoryOut;
        end
        default: ir <= 16'h0000;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge RESET) begin
    if (RESET) cstored <= 1'b0;
    else       cstored <= ALUOutFlag[2];
  end

  always_ff @(posedge Clock) begin
    if (!Mem_CS && Mem_WR) mem[Address] <= ALUOut;
  end

  assign AOut      = r[RF_OutASel];
  assign BOut      = r[RF_OutBSel];
  assign ARF_COut  = (ARF_OutCSel == 2'b00) ? ar :
                     (ARF_OutCSel == 2'b01) ? sp : pc;
  assign Address   = (ARF_OutDSel == 2'b00) ? ar :
                     (ARF_OutDSel == 2'b01) ? sp : pc;
  assign MemoryOut = (!Mem_CS && !Mem_WR) ? mem[Address] : 8'h00;
  assign IROut     = ir;
  assign MuxCOut   = MuxCSel ? ARF_COut : AOut;

  always_comb begin
    MuxAOut = ALUOut;
    MuxBOut = ALUOut;
    unique case (MuxASel)
      2'b00: MuxAOut = ALUOut;
      2'b01: MuxAOut = MemoryOut;
      2'b10: MuxAOut = ir[7:0];
      default: MuxAOut = ARF_COut;
    endcase
    unique case (MuxBSel)
      2'b00: MuxBOut = ALUOut;
      2'b01: MuxBOut = MemoryOut;
      2'b10: MuxBOut = ir[7:0];
      default: MuxBOut = ARF_COut;
    endcase
  end

  always_comb begin
    sum = 9'h000;
    res = 8'h00;
    c   = 1'b0;
    o   = 1'b0;
    unique case (ALU_FunSel)
      4'h0: res = MuxCOut;
      4'h1: res = BOut;
      4'h2: res = ~MuxCOut;
      4'h3: res = ~BOut;
      4'h4: begin
        sum = {1'b0, MuxCOut} + {1'b0, BOut};
        res = sum[7:0];
        c   = sum[8];
        o   = (MuxCOut[7] == BOut[7]) && (res[7] != MuxCOut[7]);
      end
      4'h5: begin
        sum = {1'b0, MuxCOut} + {1'b0, BOut} + {8'h00, cstored};
        res = sum[7:0];
        c   = sum[8];
        o   = (MuxCOut[7] == BOut[7]) && (res[7] != MuxCOut[7]);
      end
      4'h6: begin
        sum = {1'b0, MuxCOut} + {1'b0, ~BOut} + 9'd1;
        res = sum[7:0];
        c   = sum[8];
        o   = (MuxCOut[7] != BOut[7]) && (res[7] != MuxCOut[7]);
      end
      4'h7: res = MuxCOut & BOut;
      4'h8: res = MuxCOut | BOut;
      4'h9: res = MuxCOut ^ BOut;
      4'hA: {c, res} = {MuxCOut, 1'b0};
      4'hB: {res, c} = {1'b0, MuxCOut};
      4'hC: begin
        {c, res} = {MuxCOut, 1'b0};
        o = MuxCOut[7] ^ MuxCOut[6];
      end
      4'hD: {res, c} = {MuxCOut[7], MuxCOut};
      4'hE: begin
        res = {MuxCOut[6:0], MuxCOut[7]};
        c   = MuxCOut[7];
      end
      default: begin
        res = {MuxCOut[0], MuxCOut[7:1]};
        c   = MuxCOut[0];
      end
    endcase
  end

  assign ALUOut     = res;
  assign ALUOutFlag = {res == 8'h00, c, res[7], o};

endmodule

// File: tb/tb_alu_datapath_system.sv
// Bench for alu_datapath_system: directed literal checks plus random
// stimulus compared every cycle against an arithmetic reference model.
module tb_alu_datapath_system;

  logic        Clock = 1'b0;
  logic        RESET = 1'b0;
  logic [1:0]  RF_OutASel = '0, RF_OutBSel = '0, RF_FunSel = '0;
  logic [3:0]  RF_RegSel = 4'hF, ALU_FunSel = '0;
  logic [1:0]  ARF_OutCSel = '0, ARF_OutDSel = '0, ARF_FunSel = '0;
  logic [2:0]  ARF_RegSel = 3'h7;
  logic        IR_LH = 1'b0, IR_Enable = 1'b0;
  logic [1:0]  IR_Funsel = '0;
  logic        Mem_WR = 1'b0, Mem_CS = 1'b1;
  logic [1:0]  MuxASel = '0, MuxBSel = '0;
  logic        MuxCSel = 1'b0;
  logic [7:0]  AOut, BOut, ALUOut, ARF_COut, Address, MemoryOut;
  logic [3:0]  ALUOutFlag;
  logic [15:0] IROut;
  logic [7:0]  MuxAOut, MuxBOut, MuxCOut;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  alu_datapath_system dut (
    .Clock(Clock), .RESET(RESET),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel),
    .RF_FunSel(RF_FunSel), .RF_RegSel(RF_RegSel),
    .ALU_FunSel(ALU_FunSel),
    .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel),
    .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel),
    .IR_LH(IR_LH), .IR_Enable(IR_Enable), .IR_Funsel(IR_Funsel),
    .Mem_WR(Mem_WR), .Mem_CS(Mem_CS),
    .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel),
    .AOut(AOut), .BOut(BOut), .ALUOut(ALUOut), .ALUOutFlag(ALUOutFlag),
    .ARF_COut(ARF_COut), .Address(Address), .MemoryOut(MemoryOut),
    .IROut(IROut), .MuxAOut(MuxAOut), .MuxBOut(MuxBOut), .MuxCOut(MuxCOut)
  );

  always #5 Clock = ~Clock;

  // Reference model state: R1..R4 in m_r[0..3]
  logic [7:0]  m_r [4] = '{default: 8'h00};
  logic [7:0]  m_pc = 8'h00, m_ar = 8'h00, m_sp = 8'h00;
  logic [15:0] m_ir = 16'h0000;
  logic        m_c = 1'b0;
  logic [7:0]  m_mem [256] = '{default: 8'h00};

  typedef struct packed {
    logic [7:0]  a, b, alu;
    logic [3:0]  fl;
    logic [7:0]  cout, addr, mo;
    logic [15:0] ir;
    logic [7:0]  ma, mb, mc;
  } exp_t;

  function automatic logic [11:0] m_alu(
    input logic [7:0] a, input logic [7:0] b,
    input logic [3:0] op, input logic cin
  );
    int ua, ub, sa, sb, u, s, ci;
    logic [7:0] r;
    logic c, o;
    ua = int'(a); ub = int'(b);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    ci = cin ? 1 : 0;
    u = 0; s = 0; r = 8'h00; c = 1'b0; o = 1'b0;
    case (op)
      4'h0: r = a;
      4'h1: r = b;
      4'h2: r = 8'(255 - ua);
      4'h3: r = 8'(255 - ub);
      4'h4, 4'h5, 4'h6: begin
        if (op == 4'h6) begin
          u = ua + (255 - ub) + 1;
          s = sa - sb;
        end else begin
          u = ua + ub + ((op == 4'h5) ? ci : 0);
          s = sa + sb + ((op == 4'h5) ? ci : 0);
        end
        r = 8'(u % 256);
        c = (u > 255);
        o = (s > 127) || (s < -128);
      end
      4'h7: r = a & b;
      4'h8: r = a | b;
      4'h9: r = a ^ b;
      4'hA: begin r = 8'((ua * 2) % 256); c = (ua >= 128); end
      4'hB: begin r = 8'(ua / 2); c = (ua % 2 == 1); end
      4'hC: begin
        r = 8'((ua * 2) % 256);
        c = (ua >= 128);
        o = (sa * 2 > 127) || (sa * 2 < -128);
      end
      4'hD: begin
        r = 8'((ua >= 128) ? ua / 2 + 128 : ua / 2);
        c = (ua % 2 == 1);
      end
      4'hE: begin r = 8'((ua * 2) % 256 + ua / 128); c = (ua >= 128); end
      default: begin r = 8'(ua / 2 + (ua % 2) * 128); c = (ua % 2 == 1); end
    endcase
    return {r == 8'h00, c, r >= 8'h80, o, r};
  endfunction

  function automatic logic [7:0] m_arf(input logic [1:0] s);
    case (s)
      2'd0: return m_ar;
      2'd1: return m_sp;
      default: return m_pc;
    endcase
  endfunction

  function automatic logic [7:0] m_fun(
    input logic [7:0] q, input logic [1:0] f, input logic [7:0] d
  );
    int x;
    x = int'(q);
    case (f)
      2'd0: return 8'((x + 255) % 256);
      2'd1: return 8'((x + 1) % 256);
      2'd2: return d;
      default: return 8'h00;
    endcase
  endfunction

  function automatic exp_t m_eval();
    exp_t e;
    logic [7:0] src [4];
    e.a    = m_r[RF_OutASel];
    e.b    = m_r[RF_OutBSel];
    e.cout = m_arf(ARF_OutCSel);
    e.addr = m_arf(ARF_OutDSel);
    e.mo   = (!Mem_CS && !Mem_WR) ? m_mem[e.addr] : 8'h00;
    e.mc   = MuxCSel ? e.cout : e.a;
    {e.fl, e.alu} = m_alu(e.mc, e.b, ALU_FunSel, m_c);
    e.ir   = m_ir;
    src[0] = e.alu; src[1] = e.mo; src[2] = m_ir[7:0]; src[3] = e.cout;
    e.ma   = src[MuxASel];
    e.mb   = src[MuxBSel];
    return e;
  endfunction

  task automatic m_step();
    exp_t e;
    e = m_eval();
    if (!Mem_CS && Mem_WR) m_mem[e.addr] = e.alu;
    m_c = e.fl[2];
    for (int i = 0; i < 4; i++)
      if (!RF_RegSel[3 - i]) m_r[i] = m_fun(m_r[i], RF_FunSel, e.ma);
    if (!ARF_RegSel[2]) m_pc = m_fun(m_pc, ARF_FunSel, e.mb);
    if (!ARF_RegSel[1]) m_ar = m_fun(m_ar, ARF_FunSel, e.mb);
    if (!ARF_RegSel[0]) m_sp = m_fun(m_sp, ARF_FunSel, e.mb);
    if (IR_Enable) begin
      case (IR_Funsel)
        2'd0: m_ir = m_ir - 16'd1;
        2'd1: m_ir = m_ir + 16'd1;
        2'd2: if (IR_LH) m_ir[15:8] = e.mo; else m_ir[7:0] = e.mo;
        default: m_ir = 16'h0000;
      endcase
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_pc = 8'h00; m_ar = 8'h00; m_sp = 8'h00;
    m_ir = 16'h0000; m_c = 1'b0;
  endtask

  always @(posedge Clock or posedge RESET) begin
    if (RESET) m_reset();
    else       m_step();
  end

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Every-cycle comparison of all observation outputs against the model
  always @(negedge Clock) begin
    exp_t e;
    if (chk_en) begin
      e = m_eval();
      chk("AOut", 16'(AOut), 16'(e.a));
      chk("BOut", 16'(BOut), 16'(e.b));
      chk("ALUOut", 16'(ALUOut), 16'(e.alu));
      chk("ALUOutFlag", 16'(ALUOutFlag), 16'(e.fl));
      chk("ARF_COut", 16'(ARF_COut), 16'(e.cout));
      chk("Address", 16'(Address), 16'(e.addr));
      chk("MemoryOut", 16'(MemoryOut), 16'(e.mo));
      chk("IROut", IROut, e.ir);
      chk("MuxAOut", 16'(MuxAOut), 16'(e.ma));
      chk("MuxBOut", 16'(MuxBOut), 16'(e.mb));
      chk("MuxCOut", 16'(MuxCOut), 16'(e.mc));
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_ir(input int v);
    IR_Enable = 1'b1;
    IR_Funsel = 2'b11;
    tick();
    IR_Funsel = 2'b01;
    repeat (v) tick();
    IR_Enable = 1'b0;
  endtask

  task automatic ld_rf(input logic [3:0] mask);
    MuxASel = 2'b10; RF_FunSel = 2'b10; RF_RegSel = mask;
    tick();
    RF_RegSel = 4'hF;
  endtask

  task automatic ld_arf(input logic [2:0] mask);
    MuxBSel = 2'b10; ARF_FunSel = 2'b10; ARF_RegSel = mask;
    tick();
    ARF_RegSel = 3'h7;
  endtask

  task automatic mem_write();
    Mem_CS = 1'b0; Mem_WR = 1'b1;
    tick();
    Mem_CS = 1'b1; Mem_WR = 1'b0;
  endtask

  task automatic ar_step(input logic [1:0] f);
    ARF_FunSel = f; ARF_RegSel = 3'b101;
    tick();
    ARF_RegSel = 3'h7;
  endtask

  initial begin
    logic [11:0] pin;
    exp_t e;

    pin = m_alu(8'h7F, 8'h01, 4'h4, 1'b0); chk("pin_add", 16'(pin), 16'h0380);
    pin = m_alu(8'h33, 8'h33, 4'h6, 1'b0); chk("pin_sub", 16'(pin), 16'h0C00);
    pin = m_alu(8'h01, 8'h01, 4'h5, 1'b1); chk("pin_adc", 16'(pin), 16'h0003);
    pin = m_alu(8'h81, 8'h00, 4'hD, 1'b0); chk("pin_asr", 16'(pin), 16'h06C0);
    pin = m_alu(8'h40, 8'h00, 4'hC, 1'b0); chk("pin_asl", 16'(pin), 16'h0380);

    #1 RESET = 1'b1;
    RF_OutBSel = 2'b01;
    #10;
    chk("rst_AOut", 16'(AOut), 16'h0000);
    chk("rst_BOut", 16'(BOut), 16'h0000);
    chk("rst_IROut", IROut, 16'h0000);
    chk("rst_Address", 16'(Address), 16'h0000);
    chk("rst_ALU", 16'({ALUOutFlag, ALUOut}), 16'h0800);
    #1 RESET = 1'b0;
    chk_en = 1'b1;
    tick();

    set_ir(5);
    chk("ir_count", IROut, 16'h0005);
    ld_rf(4'b0111);
    RF_OutASel = 2'b00;
    #1 chk("rf_load_R1", 16'(AOut), 16'h0005);

    set_ir(8'h7F); ld_rf(4'b0111);
    set_ir(1);     ld_rf(4'b1011);
    MuxCSel = 1'b0; RF_OutASel = 2'b00; RF_OutBSel = 2'b01; ALU_FunSel = 4'h4;
    #1;
    chk("add_ovf_out", 16'(ALUOut), 16'h0080);
    chk("add_ovf_flag", 16'(ALUOutFlag), 16'h0003);
    e = m_eval();
    chk("add_ovf_model", 16'(e.fl), 16'h0003);

    set_ir(8'h33); ld_rf(4'b0011);
    ALU_FunSel = 4'h6;
    #1;
    chk("sub_zero_out", 16'(ALUOut), 16'h0000);
    chk("sub_zero_flag", 16'(ALUOutFlag), 16'h000C);
    set_ir(1); ld_rf(4'b0011);
    ALU_FunSel = 4'h5;
    #1 chk("adc_out", 16'(ALUOut), 16'h0003);

    set_ir(8'h10); ld_arf(3'b101);
    ARF_OutDSel = 2'b00;
    #1 chk("ar_load", 16'(Address), 16'h0010);
    set_ir(8'hA5); ld_rf(4'b0111);
    ALU_FunSel = 4'h0; MuxCSel = 1'b0; RF_OutASel = 2'b00;
    #1 chk("alu_pass_a", 16'(ALUOut), 16'h00A5);
    mem_write();
    Mem_CS = 1'b0;
    #1;
    chk("mem_rd", 16'(MemoryOut), 16'h00A5);
    chk("mem_addr", 16'(Address), 16'h0010);
    Mem_CS = 1'b1;
    #1 chk("mem_cs_off", 16'(MemoryOut), 16'h0000);

    set_ir(8'h12); ld_rf(4'b0111); mem_write();
    ar_step(2'b01);
    set_ir(8'h34); ld_rf(4'b0111); mem_write();
    ar_step(2'b00);
    IR_Enable = 1'b1; IR_Funsel = 2'b11;
    tick();
    IR_Funsel = 2'b10; IR_LH = 1'b1; Mem_CS = 1'b0; Mem_WR = 1'b0;
    tick();
    IR_Enable = 1'b0;
    #1 chk("ir_high", IROut, 16'h1200);
    ar_step(2'b01);
    IR_Enable = 1'b1; IR_LH = 1'b0;
    tick();
    IR_Enable = 1'b0; Mem_CS = 1'b1;
    #1 chk("ir_low", IROut, 16'h1234);

    set_ir(8'hFF); ld_arf(3'b011);
    ARF_OutCSel = 2'b10;
    #1 chk("pc_ff", 16'(ARF_COut), 16'h00FF);
    ARF_FunSel = 2'b01; ARF_RegSel = 3'b011;
    tick();
    ARF_RegSel = 3'h7;
    #1 chk("pc_wrap", 16'(ARF_COut), 16'h0000);
    #1 RESET = 1'b1;
    #1;
    chk("async_R1", 16'(AOut), 16'h0000);
    chk("async_IR", IROut, 16'h0000);
    chk("async_PC", 16'(ARF_COut), 16'h0000);
    #3 RESET = 1'b0;
    tick();

    repeat (3000) begin
      RF_OutASel  = 2'($urandom);
      RF_OutBSel  = 2'($urandom);
      RF_FunSel   = 2'($urandom);
      RF_RegSel   = 4'($urandom);
      ALU_FunSel  = 4'($urandom);
      ARF_OutCSel = 2'($urandom);
      ARF_OutDSel = 2'($urandom);
      ARF_FunSel  = 2'($urandom);
      ARF_RegSel  = 3'($urandom);
      IR_LH       = 1'($urandom);
      IR_Enable   = 1'($urandom);
      IR_Funsel   = 2'($urandom);
      Mem_WR      = 1'($urandom);
      Mem_CS      = 1'($urandom);
      MuxASel     = 2'($urandom);
      MuxBSel     = 2'($urandom);
      MuxCSel     = 1'($urandom);
      tick();
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
